matrix_result_reader: RTL and testbench

- Reads a completed ALU result frame back out of the shared 16-bit result memory and streams it element by element over a valid/ready interface to a consumer (display driver or host link).
- The memory layout it reads is the one the coprocessor writes:
  - Result elements sit row-major in a fixed 5x5 frame at RESULT_BASE..RESULT_BASE+24, signed 8-bit in bits [7:0].
  - The overflow flag sits in bit 0 at RESULT_BASE+25.
- Only the active NxN sub-matrix (N = matrix_size+2) is emitted; the overflow flag is read last.

---
 rtl/matrix_result_reader_pkg.sv | 31 +++
 rtl/matrix_result_reader_if.sv | 29 ++
 rtl/matrix_result_reader_walker.sv | 54 +++++
 rtl/matrix_result_reader.sv | 150 +++++++++++++++
 tb/tb_matrix_result_reader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_result_reader_pkg.sv
// Shared constants, size encodings and reader state encoding for the
// coprocessor result-frame reader.
package matrix_result_reader_pkg;

    localparam int RESULT_BASE = 25;
    localparam int OVF_OFFSET  = 25;
    localparam int MAX_DIM     = 5;
    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 16;

    typedef enum logic [1:0] {
        SIZE_2X2 = 2'b00,
        SIZE_3X3 = 2'b01,
        SIZE_4X4 = 2'b10,
        SIZE_5X5 = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_HOLD     = 3'd2,
        ST_OVF_WAIT = 3'd3,
        ST_DONE     = 3'd4
    } reader_state_t;

    // Matrix dimension N for a size code: 2..5.
    function automatic logic [2:0] dim_of(input logic [1:0] sz);
        return {1'b0, sz} + 3'd2;
    endfunction

endpackage

// File: rtl/matrix_result_reader_if.sv
// Memory read port and element stream of the result reader.
interface matrix_result_reader_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [DATA_W-1:0] mem_q;

    // Element stream: an element transfers on a rising clk edge where
    // elem_valid and elem_ready are both high; while elem_valid is high and
    // elem_ready is low, every elem_* field stays unchanged.
    logic              elem_valid;
    logic              elem_ready;
    logic [7:0]        elem_data;
    logic [2:0]        elem_row;
    logic [2:0]        elem_col;
    logic              elem_last;

    modport master (
        output mem_addr, mem_re, elem_valid, elem_data, elem_row, elem_col, elem_last,
        input  mem_q, elem_ready
    );

    modport slave (
        input  mem_addr, mem_re, elem_valid, elem_data, elem_row, elem_col, elem_last,
        output mem_q, elem_ready
    );
endinterface

// File: rtl/matrix_result_reader_walker.sv
// Row/column walker over the active NxN window of the 5-wide result frame;
// produces the last-element flag and the next read address incrementally.
module matrix_result_reader_walker
    import matrix_result_reader_pkg::*;
#(
    parameter int ADDR_W  = matrix_result_reader_pkg::ADDR_W,
    parameter int MAX_DIM = matrix_result_reader_pkg::MAX_DIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init,
    input  logic              i_advance,
    input  logic [2:0]        i_n,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [2:0]        o_row,
    output logic [2:0]        o_col,
    output logic              o_last,
    output logic [ADDR_W-1:0] o_next_addr
);

    logic [2:0] r_row;
    logic [2:0] r_col;
    logic [2:0] w_n_m1;
    logic       w_col_end;

    assign w_n_m1    = i_n - 3'd1;
    assign w_col_end = (r_col == w_n_m1);
    assign o_last    = w_col_end && (r_row == w_n_m1);
    assign o_row     = r_row;
    assign o_col     = r_col;

    // Row wrap skips the unused tail of the current frame row.
    assign o_next_addr = w_col_end
        ? i_addr + ADDR_W'(MAX_DIM) - ADDR_W'(i_n) + ADDR_W'(1)
        : i_addr + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_init) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + 3'd1;
            end else begin
                r_col <= r_col + 3'd1;
            end
        end
    end

endmodule

// File: rtl/matrix_result_reader.sv
// Streams the active NxN part of a result frame out of result memory,
// then reads the overflow flag and pulses done.
module matrix_result_reader
    import matrix_result_reader_pkg::*;
#(
    parameter int ADDR_W      = matrix_result_reader_pkg::ADDR_W,
    parameter int DATA_W      = matrix_result_reader_pkg::DATA_W,
    parameter int RESULT_BASE = matrix_result_reader_pkg::RESULT_BASE,
    parameter int MAX_DIM     = matrix_result_reader_pkg::MAX_DIM,
    parameter int RD_LAT      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [1:0]                    i_matrix_size,
    matrix_result_reader_if.master        bus,
    output logic                          o_overflow,
    output logic                          o_busy,
    output logic                          o_done,
    output reader_state_t                 o_state
);

    reader_state_t     r_state;
    logic [2:0]        r_n;
    logic [1:0]        r_lat_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_re;
    logic              r_elem_valid;
    logic [7:0]        r_elem_data;
    logic [2:0]        r_elem_row;
    logic [2:0]        r_elem_col;
    logic              r_elem_last;
    logic              r_overflow;
    logic              r_done;

    logic              w_init;
    logic              w_advance;
    logic              w_lat_hit;
    logic [2:0]        w_row;
    logic [2:0]        w_col;
    logic              w_last;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_unused_hi;

    assign w_init      = (r_state == ST_IDLE) && i_start;
    assign w_advance   = (r_state == ST_HOLD) && bus.elem_ready && !r_elem_last;
    assign w_lat_hit   = (r_lat_cnt == 2'(RD_LAT));
    assign w_unused_hi = ^bus.mem_q[DATA_W-1:8];

    matrix_result_reader_walker #(
        .ADDR_W  (ADDR_W),
        .MAX_DIM (MAX_DIM)
    ) u_walker (
        .clk         (clk),
        .rst         (rst),
        .i_init      (w_init),
        .i_advance   (w_advance),
        .i_n         (r_n),
        .i_addr      (r_mem_addr),
        .o_row       (w_row),
        .o_col       (w_col),
        .o_last      (w_last),
        .o_next_addr (w_next_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_n          <= '0;
            r_lat_cnt    <= '0;
            r_mem_addr   <= '0;
            r_mem_re     <= 1'b0;
            r_elem_valid <= 1'b0;
            r_elem_data  <= '0;
            r_elem_row   <= '0;
            r_elem_col   <= '0;
            r_elem_last  <= 1'b0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_n        <= dim_of(i_matrix_size);
                        r_mem_addr <= ADDR_W'(RESULT_BASE);
                        r_overflow <= 1'b0;
                        r_lat_cnt  <= '0;
                        r_mem_re   <= 1'b1;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_lat_hit) begin
                        r_elem_data  <= bus.mem_q[7:0];
                        r_elem_row   <= w_row;
                        r_elem_col   <= w_col;
                        r_elem_last  <= w_last;
                        r_elem_valid <= 1'b1;
                        r_mem_re     <= 1'b0;
                        r_state      <= ST_HOLD;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (bus.elem_ready) begin
                        r_elem_valid <= 1'b0;
                        r_lat_cnt    <= '0;
                        r_mem_re     <= 1'b1;
                        if (r_elem_last) begin
                            r_mem_addr <= ADDR_W'(RESULT_BASE + OVF_OFFSET);
                            r_state    <= ST_OVF_WAIT;
                        end else begin
                            r_mem_addr <= w_next_addr;
                            r_state    <= ST_WAIT;
                        end
                    end
                end
                ST_OVF_WAIT: begin
                    if (w_lat_hit) begin
                        r_overflow <= bus.mem_q[0];
                        r_done     <= 1'b1;
                        r_mem_re   <= 1'b0;
                        r_state    <= ST_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_re     = r_mem_re;
    assign bus.elem_valid = r_elem_valid;
    assign bus.elem_data  = r_elem_data;
    assign bus.elem_row   = r_elem_row;
    assign bus.elem_col   = r_elem_col;
    assign bus.elem_last  = r_elem_last;
    assign o_overflow     = r_overflow;
    assign o_done         = r_done;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_state        = r_state;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Bench for matrix_result_reader: RD_LAT=1 and RD_LAT=2 instances against a
// frame-level reference model of addresses, data, indices and timing.
module tb_matrix_result_reader;
    import matrix_result_reader_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       sel;
    logic       rdy;
    logic [1:0] msize;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [15:0] mem [128];
    logic [15:0] q1, q2a, q2b;

    matrix_result_reader_if #(.ADDR_W(7), .DATA_W(16)) bus1 ();
    matrix_result_reader_if #(.ADDR_W(7), .DATA_W(16)) bus2 ();

    always @(posedge clk) begin
        q1  <= mem[bus1.mem_addr];
        q2a <= mem[bus2.mem_addr];
        q2b <= q2a;
    end

    logic start_1, start_2;
    assign start_1          = start & ~sel;
    assign start_2          = start & sel;
    assign bus1.elem_ready  = rdy;
    assign bus2.elem_ready  = rdy;
    assign bus1.mem_q       = q1;
    assign bus2.mem_q       = q2b;

    logic ovf1, busy1, done1, ovf2, busy2, done2;
    reader_state_t st1, st2;

    matrix_result_reader #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .i_start(start_1), .i_matrix_size(msize),
        .bus(bus1), .o_overflow(ovf1), .o_busy(busy1), .o_done(done1), .o_state(st1)
    );

    matrix_result_reader #(.RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .i_start(start_2), .i_matrix_size(msize),
        .bus(bus2), .o_overflow(ovf2), .o_busy(busy2), .o_done(done2), .o_state(st2)
    );

    // Selected-instance view.
    logic       v, re, lst, ovf, busy, done;
    logic [7:0] data;
    logic [2:0] row, col;
    logic [6:0] addr;
    assign v    = sel ? bus2.elem_valid : bus1.elem_valid;
    assign re   = sel ? bus2.mem_re     : bus1.mem_re;
    assign lst  = sel ? bus2.elem_last  : bus1.elem_last;
    assign data = sel ? bus2.elem_data  : bus1.elem_data;
    assign row  = sel ? bus2.elem_row   : bus1.elem_row;
    assign col  = sel ? bus2.elem_col   : bus1.elem_col;
    assign addr = sel ? bus2.mem_addr   : bus1.mem_addr;
    assign ovf  = sel ? ovf2  : ovf1;
    assign busy = sel ? busy2 : busy1;
    assign done = sel ? done2 : done1;

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_mem_random();
        for (int a = 0; a < 128; a++) mem[a] = 16'($urandom);
    endtask

    // ---------------- driver + reference model ----------------
    // Reads one frame on instance s. rst_at >= 0 aborts the frame with an
    // asynchronous reset while element rst_at is presented.
    task automatic run_frame(input logic s, input logic [1:0] size, input int rdy_pct,
                             input logic disturb, input int stall_k, input int rst_at);
        int n, lat, k, seen_k, prev_t, t0, stall_cnt;
        logic got_done;
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic [31:0] exp_row[$];
        logic [31:0] exp_col[$];
        logic ovf_exp;

        n   = int'(size) + 2;
        lat = s ? 2 : 1;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                exp_addr.push_back(32'(25 + r * 5 + c));
                exp_data.push_back(32'(mem[25 + r * 5 + c][7:0]));
                exp_row.push_back(32'(r));
                exp_col.push_back(32'(c));
            end
        ovf_exp = mem[50][0];

        @(negedge clk);
        sel   = s;
        msize = size;
        start = 1'b1;
        @(posedge clk); #1;
        t0    = cyc;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ovf_cleared_on_start", 32'(ovf), 32'd0);
        chk("first_addr", 32'(addr), 32'd25);

        k = 0; seen_k = -1; prev_t = -1; stall_cnt = 0; got_done = 1'b0;
        rdy = ($urandom_range(0, 99) < rdy_pct);
        for (int t = 0; t < 800 && !got_done; t++) begin
            @(posedge clk); #1;
            if (rst_at >= 0 && v && k == rst_at) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_valid", 32'(v), 32'd0);
                chk("rst_addr", 32'(addr), 32'd0);
                chk("rst_re", 32'(re), 32'd0);
                chk("rst_data", 32'(data), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                @(posedge clk); #1;
                chk("rst_no_done", 32'(done), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                @(posedge clk); #1;
                chk("rst_idle_no_done", 32'(done | busy), 32'd0);
                return;
            end
            if (disturb) begin
                start = 1'($urandom);
                msize = 2'($urandom);
            end
            if (v) begin
                if (k >= n * n) begin
                    chk("extra_elem", 32'(k), 32'(n * n - 1));
                end else begin
                    chk("elem_data", 32'(data), exp_data[k]);
                    chk("elem_row", 32'(row), exp_row[k]);
                    chk("elem_col", 32'(col), exp_col[k]);
                    chk("elem_last", 32'(lst), 32'(k == n * n - 1));
                    chk("elem_addr", 32'(addr), exp_addr[k]);
                    chk("no_read_in_hold", 32'(re), 32'd0);
                    if (seen_k != k) begin
                        if (k == 0) chk("first_valid_lat", 32'(cyc - t0), 32'(lat + 1));
                        else if (rdy_pct == 100 && stall_k < 0)
                            chk("elem_interval", 32'(cyc - prev_t), 32'(lat + 2));
                        prev_t = cyc;
                        seen_k = k;
                    end
                end
            end
            if (done) begin
                got_done = 1'b1;
                chk("elem_count", 32'(k), 32'(n * n));
                chk("overflow", 32'(ovf), 32'(ovf_exp));
                chk("ovf_addr", 32'(addr), 32'd50);
                chk("done_no_read", 32'(re), 32'd0);
                if (rdy_pct == 100 && stall_k < 0)
                    chk("done_time", 32'(cyc - t0), 32'(n * n * (lat + 2) + lat + 1));
                // start in the done cycle must be ignored
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk("done_one_cycle", 32'(done), 32'd0);
                chk("idle_after_done", 32'(busy), 32'd0);
                chk("addr_kept", 32'(addr), 32'd50);
                @(posedge clk); #1;
                chk("start_in_done_ignored", 32'(busy), 32'd0);
                chk("overflow_held", 32'(ovf), 32'(ovf_exp));
            end else begin
                rdy = ($urandom_range(0, 99) < rdy_pct);
                if (v && k == stall_k && stall_cnt < 10) begin
                    rdy = 1'b0;
                    stall_cnt++;
                    chk("stall_valid_held", 32'(v), 32'd1);
                end
                if (v && rdy) k++;
            end
        end
        chk("done_seen", 32'(got_done), 32'd1);
        start = 1'b0;
        rdy   = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; rdy = 1'b0; msize = 2'b00;
        for (int a = 0; a < 128; a++) mem[a] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_addr1", 32'(bus1.mem_addr), 32'd0);
        chk("reset_valid1", 32'(bus1.elem_valid), 32'd0);
        chk("reset_busy1", 32'(busy1), 32'd0);
        chk("reset_done1", 32'(done1), 32'd0);
        chk("reset_state2", 32'(st2), 32'(ST_IDLE));
        chk("reset_re2", 32'(bus2.mem_re), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 2x2 ramp, overflow set
        for (int a = 25; a < 50; a++) mem[a] = 16'(a - 25);
        mem[50] = 16'h0001;
        run_frame(1'b0, SIZE_2X2, 100, 1'b0, -1, -1);

        // 5x5, negative element with junk upper byte, overflow clear
        fill_mem_random();
        mem[25] = 16'h12FB;
        mem[50] = 16'hFFFE;
        run_frame(1'b0, SIZE_5X5, 100, 1'b0, -1, -1);

        // 3x3 with a 10-cycle stall on element (1,0)
        fill_mem_random();
        run_frame(1'b0, SIZE_3X3, 100, 1'b0, 3, -1);

        // 5x5 aborted by reset, then a full restart
        fill_mem_random();
        run_frame(1'b0, SIZE_5X5, 100, 1'b0, -1, 7);
        run_frame(1'b0, SIZE_5X5, 70, 1'b0, -1, -1);

        // start/size noise while busy, after a frame that left overflow set
        fill_mem_random();
        mem[50] = 16'h0003;
        run_frame(1'b0, SIZE_2X2, 100, 1'b0, -1, -1);
        mem[50] = 16'h0000;
        run_frame(1'b0, SIZE_4X4, 60, 1'b1, -1, -1);

        // RD_LAT=2, 4x4
        fill_mem_random();
        run_frame(1'b1, SIZE_4X4, 100, 1'b0, -1, -1);

        for (int i = 0; i < 6; i++) begin
            fill_mem_random();
            run_frame(1'($urandom), 2'($urandom), $urandom_range(40, 100), 1'($urandom), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
